// File: rtl/alu_op_issue_if.sv
// rtl/alu_op_issue_if.sv - handshake bundle between regfile-read, the ALU issue block and execute
interface alu_op_issue_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_rs1_data;
  logic [XLEN-1:0] in_rs2_data;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_A;
  logic [XLEN-1:0] out_B;
  logic [3:0]      out_ALUOp;
  logic [4:0]      out_rd;
  logic            out_we;
  logic            out_illegal;

  // Environment side: drives instructions in, accepts decoded words out
  modport master (
    output in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    input  in_ready, out_valid, out_A, out_B, out_ALUOp, out_rd, out_we, out_illegal
  );

  // Issue block side
  modport slave (
    input  in_valid, in_instr, in_pc, in_rs1_data, in_rs2_data, out_ready,
    output in_ready, out_valid, out_A, out_B, out_ALUOp, out_rd, out_we, out_illegal
  );
endinterface

// File: rtl/alu_op_issue.sv
// rtl/alu_op_issue.sv - RV32I decode to ALUOp/operands with registered output and one-entry skid buffer
module alu_op_issue #(
  parameter int         XLEN       = 32,
  parameter logic [3:0] ILLEGAL_OP = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_op_issue_if.slave    bus
);

  generate
    if (XLEN != 32) begin : g_xlen_check
      $error("alu_op_issue: only XLEN=32 is supported");
    end
  endgenerate

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_PASS = 4'b1001;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [3:0]      op;
    logic [4:0]      rd;
    logic            we;
    logic            illegal;
  } entry_t;

  entry_t main_q, main_d, skid_q, skid_d, dec;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   in_ready_q;
  logic   accept, drain;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [XLEN-1:0] imm_i, imm_s, imm_u, imm_j;
  logic            bad;

  assign opcode = bus.in_instr[6:0];
  assign funct3 = bus.in_instr[14:12];
  assign funct7 = bus.in_instr[31:25];
  assign imm_i  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:25], bus.in_instr[11:7]};
  assign imm_u  = {bus.in_instr[31:12], 12'b0};
  assign imm_j  = {{(XLEN-21){bus.in_instr[31]}}, bus.in_instr[31], bus.in_instr[19:12],
                   bus.in_instr[20], bus.in_instr[30:21], 1'b0};

  // Decode the incoming instruction word into an issue entry
  always_comb begin
    dec         = '0;
    bad         = 1'b0;
    dec.rd      = bus.in_instr[11:7];
    dec.we      = (bus.in_instr[11:7] != 5'd0);
    unique case (opcode)
      OPC_OP: begin
        dec.a  = bus.in_rs1_data;
        dec.b  = bus.in_rs2_data;
        dec.op = {funct7[5], funct3};
        if (!(funct7 == 7'h00 || (funct7 == 7'h20 && (funct3 == 3'b000 || funct3 == 3'b101))))
          bad = 1'b1;
      end
      OPC_OP_IMM: begin
        dec.a  = bus.in_rs1_data;
        dec.b  = imm_i;
        dec.op = {(funct3 == 3'b101) ? funct7[5] : 1'b0, funct3};
        if (funct3 == 3'b001 && funct7 != 7'h00)
          bad = 1'b1;
        if (funct3 == 3'b101 && funct7 != 7'h00 && funct7 != 7'h20)
          bad = 1'b1;
      end
      OPC_LUI: begin
        dec.b  = imm_u;
        dec.op = ALU_PASS;
      end
      OPC_AUIPC: begin
        dec.a  = bus.in_pc;
        dec.b  = imm_u;
        dec.op = ALU_ADD;
      end
      OPC_LOAD, OPC_JALR: begin
        dec.a  = bus.in_rs1_data;
        dec.b  = imm_i;
        dec.op = ALU_ADD;
      end
      OPC_STORE: begin
        dec.a  = bus.in_rs1_data;
        dec.b  = imm_s;
        dec.op = ALU_ADD;
        dec.we = 1'b0;
      end
      OPC_JAL: begin
        dec.a  = bus.in_pc;
        dec.b  = imm_j;
        dec.op = ALU_ADD;
      end
      OPC_BRANCH: begin
        dec.a  = bus.in_rs1_data;
        dec.b  = bus.in_rs2_data;
        dec.we = 1'b0;
        unique case (funct3[2:1])
          2'b00:   dec.op = ALU_SUB;
          2'b10:   dec.op = ALU_SLT;
          2'b11:   dec.op = ALU_SLTU;
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
    // Undecodable words still carry rd so later stages can report it
    if (bad) begin
      dec.a       = '0;
      dec.b       = '0;
      dec.op      = ILLEGAL_OP;
      dec.we      = 1'b0;
      dec.illegal = 1'b1;
    end
  end

  assign accept = bus.in_valid & in_ready_q;
  assign drain  = main_valid_q & bus.out_ready;

  // Next state of the main/skid pair; skid always refills main before new data so order is kept
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || drain) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = accept;
        if (accept) skid_d = dec;
      end else begin
        main_valid_d = accept;
        if (accept) main_d = dec;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  // State registers; in_ready held low in reset and tracks skid-empty afterwards
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= !skid_valid_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = main_valid_q;
  assign bus.out_A       = main_q.a;
  assign bus.out_B       = main_q.b;
  assign bus.out_ALUOp   = main_q.op;
  assign bus.out_rd      = main_q.rd;
  assign bus.out_we      = main_q.we;
  assign bus.out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_op_issue.sv
// tb/tb_alu_op_issue.sv - directed self-checking bench for alu_op_issue
module tb_alu_op_issue;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  alu_op_issue_if #(.XLEN(32)) bus ();

  alu_op_issue dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_out(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [4:0] rd, input logic we,
                         input logic ill);
    chk({tag, ".valid"}, {31'b0, bus.out_valid}, 32'd1);
    chk({tag, ".A"}, bus.out_A, a);
    chk({tag, ".B"}, bus.out_B, b);
    chk({tag, ".op"}, {28'b0, bus.out_ALUOp}, {28'b0, op});
    chk({tag, ".rd"}, {27'b0, bus.out_rd}, {27'b0, rd});
    chk({tag, ".we"}, {31'b0, bus.out_we}, {31'b0, we});
    chk({tag, ".ill"}, {31'b0, bus.out_illegal}, {31'b0, ill});
  endtask

  // Offer one instruction with the sink ready; it is on the outputs right after the edge
  task automatic send_one(input logic [31:0] instr, input logic [31:0] pc,
                          input logic [31:0] rs1, input logic [31:0] rs2);
    @(negedge clk);
    bus.in_valid    = 1'b1;
    bus.in_instr    = instr;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    bus.out_ready   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  logic [31:0] stream [4];
  logic [31:0] got [$];
  int          idx;
  logic        xin, xout;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_instr    = '0;
    bus.in_pc       = '0;
    bus.in_rs1_data = '0;
    bus.in_rs2_data = '0;
    bus.out_ready   = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("rst.in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("rst.out_A", bus.out_A, 32'd0);
    chk("rst.out_ALUOp", {28'b0, bus.out_ALUOp}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rel.in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rel.out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Single instructions through an empty pipe
    send_one(32'h002081B3, 32'h0, 32'd5, 32'd7);
    chk_out("add", 32'd5, 32'd7, 4'b0000, 5'd3, 1'b1, 1'b0);
    send_one(32'h402081B3, 32'h0, 32'd10, 32'd3);
    chk_out("sub", 32'd10, 32'd3, 4'b1000, 5'd3, 1'b1, 1'b0);
    send_one(32'h4040D193, 32'h0, 32'h80000000, 32'h0);
    chk_out("srai", 32'h80000000, 32'h00000404, 4'b1101, 5'd3, 1'b1, 1'b0);
    send_one(32'hFFF08093, 32'h0, 32'd9, 32'h0);
    chk_out("addi", 32'd9, 32'hFFFFFFFF, 4'b0000, 5'd1, 1'b1, 1'b0);
    send_one(32'h123452B7, 32'h0, 32'hDEAD, 32'h0);
    chk_out("lui", 32'h0, 32'h12345000, 4'b1001, 5'd5, 1'b1, 1'b0);
    send_one(32'h00001317, 32'h100, 32'hDEAD, 32'h0);
    chk_out("auipc", 32'h100, 32'h00001000, 4'b0000, 5'd6, 1'b1, 1'b0);
    send_one(32'h0020E463, 32'h0, 32'd1, 32'h55);
    chk_out("bltu", 32'd1, 32'h55, 4'b0011, 5'd8, 1'b0, 1'b0);
    send_one(32'hFFFFFFFF, 32'h0, 32'd1, 32'd2);
    chk_out("illegal", 32'h0, 32'h0, 4'b0000, 5'd31, 1'b0, 1'b1);
    send_one(32'h40109093, 32'h0, 32'd1, 32'd2);
    chk_out("slli_f7", 32'h0, 32'h0, 4'b0000, 5'd1, 1'b0, 1'b1);
    send_one(32'h4020F1B3, 32'h0, 32'd1, 32'd2);
    chk_out("and_f7", 32'h0, 32'h0, 4'b0000, 5'd3, 1'b0, 1'b1);
    send_one(32'h0020A423, 32'h0, 32'h1000, 32'd2);
    chk_out("sw", 32'h1000, 32'd8, 4'b0000, 5'd8, 1'b0, 1'b0);
    send_one(32'h001000EF, 32'h200, 32'd0, 32'd0);
    chk_out("jal", 32'h200, 32'h800, 4'b0000, 5'd1, 1'b1, 1'b0);
    send_one(32'h00208033, 32'h0, 32'd1, 32'd2);
    chk_out("add_x0", 32'd1, 32'd2, 4'b0000, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    chk("drained.out_valid", {31'b0, bus.out_valid}, 32'd0);

    // Stall with sink blocked for 4 cycles, then release; ADDI x1,x0,k carries k on B
    stream[0] = 32'h01100093;
    stream[1] = 32'h02200093;
    stream[2] = 32'h03300093;
    stream[3] = 32'h04400093;
    idx = 0;
    got.delete();
    for (int cyc = 0; cyc < 20 && got.size() < 4; cyc++) begin
      @(negedge clk);
      bus.in_valid    = (idx < 4);
      bus.in_instr    = stream[idx < 4 ? idx : 3];
      bus.in_rs1_data = 32'h0;
      bus.out_ready   = (cyc >= 4);
      #1;
      if (cyc == 4) begin
        chk("stall.accepted", idx, 32'd2);
        chk("stall.in_ready", {31'b0, bus.in_ready}, 32'd0);
        chk("stall.head_B", bus.out_B, 32'h11);
      end
      xin  = bus.in_valid & bus.in_ready;
      xout = bus.out_valid & bus.out_ready;
      if (xout) got.push_back(bus.out_B);
      @(posedge clk);
      if (xin) idx++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("stream.count", got.size(), 32'd4);
    chk("stream.0", (got.size() > 0) ? got[0] : 32'hX, 32'h11);
    chk("stream.1", (got.size() > 1) ? got[1] : 32'hX, 32'h22);
    chk("stream.2", (got.size() > 2) ? got[2] : 32'hX, 32'h33);
    chk("stream.3", (got.size() > 3) ? got[3] : 32'hX, 32'h44);
    @(posedge clk);
    #1;
    chk("stream.no_dup", {31'b0, bus.out_valid}, 32'd0);

    // Fill main and skid, then assert reset between edges
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_instr  = stream[0];
    @(negedge clk);
    bus.in_instr  = stream[1];
    @(negedge clk);
    bus.in_valid  = 1'b0;
    chk("full.in_ready", {31'b0, bus.in_ready}, 32'd0);
    chk("full.out_valid", {31'b0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async.out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("async.in_ready", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("restart.in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("restart.out_valid", {31'b0, bus.out_valid}, 32'd0);
    send_one(32'h002081B3, 32'h0, 32'd20, 32'd22);
    chk_out("restart.add", 32'd20, 32'd22, 4'b0000, 5'd3, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    chk("restart.drain", {31'b0, bus.out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
